// File: rtl/mult_unit.sv
// Sequential signed 32x32 radix-2 Booth multiplier: one step per clock, 64-bit product to HI/LO.
// A single-cycle MultCtrl pulse in IDLE starts a run; MultDone pulses once when HI/LO update.
module mult_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] RegAOut,
  input  logic [31:0] RegBOut,
  input  logic        MultCtrl,
  output logic        MultDone,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      r_state, w_state_d;
  logic [32:0] r_m, w_m_d;
  logic [32:0] r_acc, w_acc_d;
  logic [31:0] r_q, w_q_d;
  logic        r_qm1, w_qm1_d;
  logic [5:0]  r_count, w_count_d;
  logic [31:0] r_hi, w_hi_d;
  logic [31:0] r_lo, w_lo_d;
  logic        r_done, w_done_d;

  logic [32:0] w_sum;
  logic [32:0] w_acc_sh;
  logic [31:0] w_q_sh;

  // Booth recode on (Q[0], q-1); the 33-bit acc keeps -2^31 * -2^31 exact.
  always_comb begin
    unique case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + r_m;
      2'b10:   w_sum = r_acc - r_m;
      default: w_sum = r_acc;
    endcase
    w_acc_sh = {w_sum[32], w_sum[32:1]};
    w_q_sh   = {w_sum[0], r_q[31:1]};
  end

  always_comb begin
    w_state_d = r_state;
    w_m_d     = r_m;
    w_acc_d   = r_acc;
    w_q_d     = r_q;
    w_qm1_d   = r_qm1;
    w_count_d = r_count;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    w_done_d  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (MultCtrl) begin
          w_m_d     = {RegAOut[31], RegAOut};
          w_acc_d   = '0;
          w_q_d     = RegBOut;
          w_qm1_d   = 1'b0;
          w_count_d = '0;
          w_state_d = StRun;
        end
      end
      StRun: begin
        w_acc_d   = w_acc_sh;
        w_q_d     = w_q_sh;
        w_qm1_d   = r_q[0];
        w_count_d = r_count + 6'd1;
        if (r_count == 6'd31) begin
          w_hi_d    = w_acc_sh[31:0];
          w_lo_d    = w_q_sh;
          w_done_d  = 1'b1;
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_qm1   <= 1'b0;
      r_count <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_m     <= w_m_d;
      r_acc   <= w_acc_d;
      r_q     <= w_q_d;
      r_qm1   <= w_qm1_d;
      r_count <= w_count_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
      r_done  <= w_done_d;
    end
  end

  assign MultDone = r_done;
  assign HI       = r_hi;
  assign LO       = r_lo;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed corner products, reset abort, mid-run disturbance,
// and random operands checked against a plain signed 64-bit multiply.
module tb_mult_unit;

  logic        clk;
  logic        reset;
  logic [31:0] RegAOut;
  logic [31:0] RegBOut;
  logic        MultCtrl;
  logic        MultDone;
  logic [31:0] HI;
  logic [31:0] LO;

  int unsigned n_chk;
  int unsigned n_fail;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mult_unit dut (
    .clk      (clk),
    .reset    (reset),
    .RegAOut  (RegAOut),
    .RegBOut  (RegBOut),
    .MultCtrl (MultCtrl),
    .MultDone (MultDone),
    .HI       (HI),
    .LO       (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge. disturb!=0 re-pulses MultCtrl with fresh operands mid-run.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input bit disturb,
                          input int post);
    logic signed [63:0] p;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    RegAOut  = a;
    RegBOut  = b;
    MultCtrl = 1'b1;
    @(posedge clk); #1;
    MultCtrl = 1'b0;
    RegAOut  = $urandom;
    RegBOut  = $urandom;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      if (c < 32) begin
        chk("done_early", {31'd0, MultDone}, 32'd0);
        chk("hi_hold_run", HI, exp_hi);
        chk("lo_hold_run", LO, exp_lo);
      end else begin
        exp_hi = p[63:32];
        exp_lo = p[31:0];
        chk("done_at_32", {31'd0, MultDone}, 32'd1);
        chk("hi_result", HI, exp_hi);
        chk("lo_result", LO, exp_lo);
      end
      MultCtrl = disturb && (c == 5 || c == 31);
      if (MultCtrl) begin
        RegAOut = $urandom;
        RegBOut = $urandom;
      end
    end
    MultCtrl = 1'b0;
    for (int c = 0; c < post; c++) begin
      @(posedge clk); #1;
      chk("done_after", {31'd0, MultDone}, 32'd0);
      chk("hi_hold_after", HI, exp_hi);
      chk("lo_hold_after", LO, exp_lo);
    end
  endtask

  initial begin
    logic [31:0] corner [6];
    logic [31:0] ra, rb;
    n_chk    = 0;
    n_fail   = 0;
    exp_hi   = '0;
    exp_lo   = '0;
    reset    = 1'b1;
    RegAOut  = '0;
    RegBOut  = '0;
    MultCtrl = 1'b0;
    corner   = '{32'h0, 32'h1, 32'hffffffff, 32'h80000000, 32'h7fffffff, 32'h80000001};
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", HI, 32'h0);
    chk("reset_lo", LO, 32'h0);
    chk("reset_done", {31'd0, MultDone}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_mult(32'd4, 32'd3, 1'b0, 3);
    chk("tp_4x3_lo", LO, 32'h0000000c);
    run_mult(32'hfffffffb, 32'd6, 1'b0, 1);
    chk("tp_m5x6_hi", HI, 32'hffffffff);
    chk("tp_m5x6_lo", LO, 32'hffffffe2);
    run_mult(32'h80000000, 32'd2, 1'b0, 1);
    chk("tp_min_x2_hi", HI, 32'hffffffff);
    run_mult(32'h80000000, 32'h80000000, 1'b0, 1);
    chk("tp_min_sq_hi", HI, 32'h40000000);
    chk("tp_min_sq_lo", LO, 32'h00000000);
    run_mult(32'h7fffffff, 32'hffffffff, 1'b0, 1);
    chk("tp_max_xm1_lo", LO, 32'h80000001);

    // Abort 7x9 with reset ten cycles into the run.
    RegAOut  = 32'd7;
    RegBOut  = 32'd9;
    MultCtrl = 1'b1;
    @(posedge clk); #1;
    MultCtrl = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    chk("abort_hi", HI, 32'h0);
    chk("abort_lo", LO, 32'h0);
    chk("abort_done", {31'd0, MultDone}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'd0, MultDone}, 32'd0);
    end
    run_mult(32'd7, 32'd9, 1'b0, 1);
    chk("tp_7x9_lo", LO, 32'h0000003f);
    chk("tp_7x9_hi", HI, 32'h0);

    // Re-pulsing MultCtrl and changing operands mid-run must not disturb the result.
    run_mult(32'd4, 32'd3, 1'b1, 36);
    chk("disturb_lo", LO, 32'h0000000c);

    for (int i = 0; i < 16; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      run_mult(ra, rb, i[0], 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
